// File: rtl/alarm_buzzer_pio_pkg.sv
// Shared constants for the alarm LED/buzzer output port: register map and field widths.
package alarm_pio_pkg;

   localparam logic [2:0] ADDR_DATA       = 3'd0;
   localparam logic [2:0] ADDR_BLINK_MASK = 3'd2;
   localparam logic [2:0] ADDR_PERIOD     = 3'd3;
   localparam logic [2:0] ADDR_OUTSET     = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;
   localparam logic [2:0] ADDR_STATUS     = 3'd6;

   localparam int PERIOD_W = 16;

endpackage

// File: rtl/alarm_buzzer_pio_if.sv
// Avalon-MM slave bus bundle between the system interconnect and the alarm output port.
interface alarm_buzzer_pio_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/alarm_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks; clear restarts the count.
module alarm_tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] r_cnt;

   assign tick = (r_cnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alarm_buzzer_pio.sv
// Avalon-MM output port for alarm LEDs/buzzer: data register with atomic set/clear,
// per-bit blink gating driven by a tick-based half-period engine.
module alarm_buzzer_pio
   import alarm_pio_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int TICK_DIV = 50000
) (
   input  logic                clk,
   input  logic                reset,
   alarm_buzzer_pio_if.slave   bus,
   output logic [WIDTH-1:0]    out_port
);

   logic [WIDTH-1:0]    r_data;
   logic [WIDTH-1:0]    r_mask;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_hp_cnt;
   logic                r_phase;
   logic [WIDTH-1:0]    r_out;
   logic [31:0]         r_rdata;

   logic                w_wr;
   logic                w_wr_period;
   logic                w_tick;
   logic [WIDTH-1:0]    w_wd;
   logic [WIDTH-1:0]    w_data_nxt;
   logic                w_phase_nxt;
   logic [PERIOD_W-1:0] w_hp_nxt;
   logic [31:0]         w_rd_nxt;

   assign w_wr        = bus.chipselect & ~bus.write_n;
   assign w_wr_period = w_wr && (bus.address == ADDR_PERIOD);
   assign w_wd        = bus.writedata[WIDTH-1:0];

   alarm_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (w_wr_period),
      .tick  (w_tick)
   );

   always_comb begin
      w_data_nxt = r_data;
      if (w_wr) begin
         case (bus.address)
            ADDR_DATA:     w_data_nxt = w_wd;
            ADDR_OUTSET:   w_data_nxt = r_data | w_wd;
            ADDR_OUTCLEAR: w_data_nxt = r_data & ~w_wd;
            default:       w_data_nxt = r_data;
         endcase
      end
   end

   // A PERIOD write outranks a coincident tick so blinking restarts from a known phase.
   always_comb begin
      w_phase_nxt = r_phase;
      w_hp_nxt    = r_hp_cnt;
      if (w_wr_period || (r_period == '0)) begin
         w_phase_nxt = 1'b1;
         w_hp_nxt    = '0;
      end else if (w_tick) begin
         if (r_hp_cnt == (r_period - PERIOD_W'(1))) begin
            w_phase_nxt = ~r_phase;
            w_hp_nxt    = '0;
         end else begin
            w_hp_nxt    = r_hp_cnt + PERIOD_W'(1);
         end
      end
   end

   always_comb begin
      w_rd_nxt = '0;
      case (bus.address)
         ADDR_DATA:       w_rd_nxt[WIDTH-1:0]    = r_data;
         ADDR_BLINK_MASK: w_rd_nxt[WIDTH-1:0]    = r_mask;
         ADDR_PERIOD:     w_rd_nxt[PERIOD_W-1:0] = r_period;
         ADDR_STATUS:     w_rd_nxt[0]            = r_phase;
         default:         w_rd_nxt               = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data   <= '0;
         r_mask   <= '0;
         r_period <= '0;
         r_hp_cnt <= '0;
         r_phase  <= 1'b1;
         r_out    <= '0;
         r_rdata  <= '0;
      end else begin
         r_data   <= w_data_nxt;
         if (w_wr && (bus.address == ADDR_BLINK_MASK)) begin
            r_mask <= w_wd;
         end
         if (w_wr_period) begin
            r_period <= bus.writedata[PERIOD_W-1:0];
         end
         r_hp_cnt <= w_hp_nxt;
         r_phase  <= w_phase_nxt;
         r_out    <= r_data & (~r_mask | {WIDTH{r_phase}});
         r_rdata  <= w_rd_nxt;
      end
   end

   assign out_port     = r_out;
   assign bus.readdata = r_rdata;

endmodule

// File: doc/alarm_buzzer_pio.md
# alarm_buzzer_pio

Avalon-MM slave output port driving the alarm's LEDs and buzzer lines: the write-side counterpart to the slider input port on the same Nios II system bus. Software writes a data register, or uses atomic bit set/clear. Selected bits can be made to blink at a programmable half-period derived from an internal millisecond-scale tick. Sits on the system interconnect next to the input PIOs; `out_port` goes to board pins.

## Interface
- `WIDTH`, 8 – number of output bits, 1..32.
- `TICK_DIV`, 50000 – clk cycles per blink tick (1 ms at 50 MHz), ≥2.

- `clk`  in  1 – system clock.
- `reset`  in  1 – asynchronous, active-high reset.
- `address`  in  3 – word register offset.
- `chipselect`  in  1 – slave select.
- `write_n`  in  1 – active-low write strobe; write = `chipselect & ~write_n`.
- `writedata`  in  32 – write data; bits ≥WIDTH ignored.
- `readdata`  out  32 – registered read data, zero-extended.
- `out_port`  out  WIDTH – registered output pins.

## Operation
- Registers, by address:
  - 0 DATA (RW) – output value.
  - 1 reserved (reads 0).
  - 2 BLINK_MASK (RW, WIDTH bits) – bits that blink.
  - 3 PERIOD (RW, 16 bits) – blink half-period in ticks.
  - 4 OUTSET (W) – DATA |= writedata; reads 0.
  - 5 OUTCLEAR (W) – DATA &= ~writedata; reads 0.
  - 6 STATUS (R) – bit0 = blink phase, others 0.
  - 7 reserved (reads 0).
- Writes to read-only or reserved addresses have no effect.
- Tick generator: free-running prescaler counting 0..TICK_DIV-1. `tick` is a one-cycle pulse when the count equals TICK_DIV-1, after which the prescaler wraps to 0.
- Blink engine:
  - Half-period counter `hp_cnt` advances on each tick.
  - On a tick with `hp_cnt == PERIOD-1`: phase toggles and `hp_cnt` returns to 0.
  - PERIOD = 0 disables blinking: phase is forced to 1 and `hp_cnt` is held at 0.
- A write to PERIOD clears the prescaler and `hp_cnt` and sets phase to 1, so blinking restarts cleanly.
- Output: `out_port[i] = DATA[i] & (~BLINK_MASK[i] | phase)`. Blinking bits are forced low during phase 0; non-blinking bits follow DATA.
- Reset values: DATA 0, BLINK_MASK 0, PERIOD 0, phase 1, prescaler 0, `hp_cnt` 0, `out_port` 0, `readdata` 0.
- Reset asserted mid-blink returns everything to the reset values immediately. The first tick after release occurs TICK_DIV cycles later.

## Timing
- Write: register updates on the clk edge where the write is sampled. `out_port` reflects the new value on the following edge (1-cycle latency).
- Read: `readdata` is registered every cycle from the current `address`, independent of `chipselect`. Data is valid one cycle after the address is presented (read latency 1).
- A read in the cycle after a write to the same register returns the new value.
- Phase toggle: phase changes on the edge of the qualifying tick; `out_port` follows one cycle later.
- Tick and PERIOD write in the same cycle: the write wins (counters cleared, phase = 1, no toggle).
- Tick and OUTSET/OUTCLEAR in the same cycle: both take effect. Gating uses the new DATA and the new phase.

## Structure
- Shared package `alarm_pio_pkg` holds:
  - register offset constants: ADDR_DATA, ADDR_BLINK_MASK, ADDR_PERIOD, ADDR_OUTSET, ADDR_OUTCLEAR, ADDR_STATUS;
  - PERIOD width constant (16).
- Sub-module `alarm_tick_gen` (parameter TICK_DIV; inputs `clk`, `reset`, `clear`; output `tick`). The top-level keeps the registers, blink engine, read mux and output gating.

## Test plan
Bench uses WIDTH=8, TICK_DIV=4.
- Reset, then read every address → `readdata` 0 and `out_port` 0.
- Write DATA=0xA5 → `out_port` 0xA5 one cycle later; read addr 0 → 0xA5.
- Write OUTSET=0x0F, then OUTCLEAR=0x81 → DATA 0xAF, then 0x2E; `out_port` tracks with 1-cycle lag.
- DATA=0xFF, BLINK_MASK=0x03, PERIOD=2 → `out_port` bits[1:0] toggle every 8 cycles while bits[7:2] stay high. STATUS bit0 matches phase.
- PERIOD=0 while blinking → phase 1 and `out_port` 0xFF steadily. Rewrite PERIOD=3 exactly on a tick cycle → no toggle that cycle; first toggle 12 cycles later.
- Assert reset mid-blink for 1 cycle → all outputs 0 immediately. Writes with chipselect=0, and writes to addr 6/7, leave state unchanged.
